smpl_capture: RTL and testbench
===============================

// Module: smpl_capture
// PURPOSE
//  Downstream consumer of the 2-channel sampler's packed smpl byte (4 time-ordered samples x CH_Low/CH_High).
//  - Decimates the valid sample bytes.
//  - Writes them into an external circular capture RAM, with a programmable pre-trigger depth.
//  - Stops after the post-trigger fill and reports the trigger address to the UART/readout logic.
// PARAMETERS
//  ADDR_W   9    capture RAM address width; DEPTH = 2**ADDR_W entries of 8 bits
//  DEC_W    4    width of decimator field; decimation ratio = 2**decimator
// PORTS
//  clk          in   1       system clock (same clk as sampler output register)
//  rst          in   1       synchronous, active-high reset
//  smpl         in   8       packed sample byte from sampler
//  smpl_vld     in   1       1-clk pulse: smpl holds a new byte this cycle
//  decimator    in   DEC_W   keep 1 of every 2**decimator valid bytes; static while capturing
//  trig_pos     in   ADDR_W  number of pre-trigger bytes to retain; static while capturing
//  arm          in   1       1-clk pulse: start a capture (honoured only in IDLE)
//  trig         in   1       trigger event from trigger logic (level or pulse)
//  clr_done     in   1       1-clk pulse: acknowledge done, return to IDLE
//  we           out  1       RAM write enable
//  waddr        out  ADDR_W  RAM write address
//  wdata        out  8       RAM write data
//  armed        out  1       high in PRETRIG and WAIT_TRIG
//  triggered    out  1       high in POST and DONE
//  capture_done out  1       high in DONE
//  trig_addr    out  ADDR_W  address written by the first post-trigger byte
// BEHAVIOUR
//  Reset: state=IDLE; we/armed/triggered/capture_done=0; waddr, wdata, trig_addr, all counters = 0.
//  Reset mid-capture aborts immediately; RAM contents are don't-care.
//  Decimation:
//   - dec_cnt (2**DEC_W-1 bits wide) counts smpl_vld.
//   - A byte is "kept" when smpl_vld && dec_cnt==(1<<decimator)-1; dec_cnt then wraps to 0, else increments.
//   - decimator=0 keeps every valid byte. dec_cnt clears on arm.
//  Write path:
//   - A kept byte in PRETRIG/WAIT_TRIG/POST gives we=1 exactly one clk later, with wdata=that smpl and waddr=wr_ptr.
//   - wr_ptr increments after each write, modulo DEPTH (wraps DEPTH-1 -> 0). No writes in IDLE or DONE.
//  FSM (states IDLE, PRETRIG, WAIT_TRIG, POST, DONE):
//   - IDLE: arm -> PRETRIG; wr_ptr, dec_cnt, pre_cnt, post_cnt cleared.
//   - PRETRIG: pre_cnt counts kept bytes.
//     - When pre_cnt==trig_pos -> WAIT_TRIG; with trig_pos=0 this happens the cycle after arm.
//     - trig in PRETRIG is ignored, so the pre-trigger window is always full.
//   - WAIT_TRIG: circular writes continue. trig -> POST; trig_addr <= wr_ptr.
//     - If a kept byte coincides with trig, that byte is the first post-trigger byte and its address is trig_addr.
//   - POST: post_cnt counts kept bytes, including the one coincident with trig.
//     - When post_cnt==DEPTH-trig_pos -> DONE; the last write lands at trig_addr-trig_pos-1 mod DEPTH.
//   - DONE: capture_done=1, outputs held. clr_done -> IDLE.
//     - If arm and clr_done coincide, clr_done wins; arm is dropped.
//   - arm outside IDLE is ignored; clr_done outside DONE is ignored.
//  Width rules:
//   - post_cnt and pre_cnt are ADDR_W+1 bits so that DEPTH-trig_pos is representable.
//   - Oldest byte in RAM at DONE = trig_addr - trig_pos mod DEPTH.
// STRUCTURE
//  - Package capture_pkg: typedef enum logic [2:0] cap_state_t {IDLE,PRETRIG,WAIT_TRIG,POST,DONE}; localparam ADDR_W default.
//  - Sub-module smpl_decimator: dec_cnt plus the keep strobe.
//  - Top level holds the FSM, pointers, counters and output registers.
// TESTING
//  1. Reset mid-POST -> next clk state=IDLE, we=0, capture_done=0, waddr=0, trig_addr=0.
//  2. decimator=0, trig_pos=0, arm, smpl_vld every clk, trig on 3rd byte.
//     -> trig_addr=2, 512 post writes, capture_done asserted, last waddr=1.
//  3. decimator=2, smpl_vld continuous -> we pulses every 4th valid; wdata equals smpl of the 4th, 8th, ... byte.
//  4. trig_pos=100, trig asserted during PRETRIG -> ignored; WAIT_TRIG entered after 100 kept bytes.
//     Later trig at wr_ptr=300 -> trig_addr=300, 412 post bytes, oldest = 200.
//  5. Wrap: trig_pos=500 with long WAIT_TRIG (>DEPTH bytes) -> waddr wraps 511->0 with no gap or duplicate.
//  6. In DONE, arm+clr_done same clk -> IDLE, not PRETRIG. Arm in WAIT_TRIG -> no effect on counters.

Source files
------------

// File: rtl/smpl_capture_pkg.sv
// capture_pkg: shared types and default sizes for the sample-capture block.
//   cap_state_t  - capture FSM states
//   CAP_ADDR_W   - default capture RAM address width (DEPTH = 2**CAP_ADDR_W)
//   CAP_DEC_W    - default width of the decimator ratio field
//   cap_is_writing() - states in which kept bytes are written to the RAM
package capture_pkg;

  localparam int CAP_ADDR_W = 9;
  localparam int CAP_DEC_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    WAIT_TRIG,
    POST,
    DONE
  } cap_state_t;

  function automatic logic cap_is_writing(input cap_state_t s);
    return (s == PRETRIG) || (s == WAIT_TRIG) || (s == POST);
  endfunction

endpackage

// File: rtl/smpl_capture_decimator.sv
// smpl_decimator: keeps 1 of every 2**decimator valid sample bytes.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   clr       in   restart the decimation count (capture start)
//   smpl_vld  in   a new sample byte is present this cycle
//   decimator in   log2 of the decimation ratio, static while capturing
//   keep      out  combinational strobe: the byte presented this cycle is kept
module smpl_decimator #(
  parameter int DEC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             smpl_vld,
  input  logic [DEC_W-1:0] decimator,
  output logic             keep
);

  // Wide enough to hold 2**(2**DEC_W-1)-1, the largest terminal count.
  localparam int CNT_W = 2**DEC_W - 1;

  logic [CNT_W-1:0] dec_cnt_reg;
  logic [CNT_W:0]   ratio;
  logic [CNT_W-1:0] dec_max;

  // ratio is one bit wider so that the largest ratio minus one truncates
  // cleanly to an all-ones terminal count.
  always_comb begin
    ratio   = (CNT_W+1)'(1) << decimator;
    dec_max = CNT_W'(ratio - 1'b1);
  end

  assign keep = smpl_vld && (dec_cnt_reg == dec_max);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      dec_cnt_reg <= '0;
    end else if (smpl_vld) begin
      if (keep) dec_cnt_reg <= '0;
      else      dec_cnt_reg <= dec_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/smpl_capture.sv
// smpl_capture: decimates the sampler's packed bytes and writes them into an
// external circular capture RAM with a programmable pre-trigger depth, then
// stops once the post-trigger part of the RAM has been filled.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   smpl/smpl_vld packed sample byte and its 1-clk valid strobe
//   decimator     log2 decimation ratio (static while capturing)
//   trig_pos      number of pre-trigger bytes to retain (static while capturing)
//   arm           start a capture (only from IDLE)
//   trig          trigger event, level or pulse
//   clr_done      acknowledge a finished capture, back to IDLE
//   we/waddr/wdata capture RAM write port (registered)
//   armed         high in PRETRIG and WAIT_TRIG
//   triggered     high in POST and DONE
//   capture_done  high in DONE
//   trig_addr     RAM address of the first post-trigger byte
module smpl_capture
  import capture_pkg::*;
#(
  parameter int ADDR_W = CAP_ADDR_W,
  parameter int DEC_W  = CAP_DEC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        smpl,
  input  logic              smpl_vld,
  input  logic [DEC_W-1:0]  decimator,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              arm,
  input  logic              trig,
  input  logic              clr_done,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [7:0]        wdata,
  output logic              armed,
  output logic              triggered,
  output logic              capture_done,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam int DEPTH = 2**ADDR_W;

  cap_state_t        state_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W:0]   pre_cnt_reg;
  logic [ADDR_W:0]   post_cnt_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [7:0]        wdata_reg;
  logic              armed_reg;
  logic              triggered_reg;
  logic              done_reg;
  logic [ADDR_W-1:0] trig_addr_reg;

  logic              keep;
  logic              dec_clr;
  logic              write_en;
  logic [ADDR_W:0]   post_limit;
  logic [ADDR_W:0]   post_cnt_next;

  assign dec_clr = (state_reg == IDLE) && arm;

  smpl_decimator #(
    .DEC_W(DEC_W)
  ) u_decimator (
    .clk      (clk),
    .rst      (rst),
    .clr      (dec_clr),
    .smpl_vld (smpl_vld),
    .decimator(decimator),
    .keep     (keep)
  );

  assign write_en = keep && cap_is_writing(state_reg);

  // Post-trigger quota fills the rest of the RAM so the pre-trigger bytes
  // survive. The count is taken including the current byte so the last write
  // and the move to DONE happen together and nothing overwrites the oldest
  // pre-trigger byte. post_cnt_reg is zero in WAIT_TRIG (cleared on arm).
  assign post_limit    = (ADDR_W+1)'(DEPTH) - {1'b0, trig_pos};
  assign post_cnt_next = post_cnt_reg + {{ADDR_W{1'b0}}, keep};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      pre_cnt_reg   <= '0;
      post_cnt_reg  <= '0;
      we_reg        <= 1'b0;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
      armed_reg     <= 1'b0;
      triggered_reg <= 1'b0;
      done_reg      <= 1'b0;
      trig_addr_reg <= '0;
    end else begin
      we_reg <= write_en;
      if (write_en) begin
        waddr_reg  <= wr_ptr_reg;
        wdata_reg  <= smpl;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;  // natural wrap at DEPTH
      end

      case (state_reg)
        IDLE: begin
          if (arm) begin
            state_reg    <= PRETRIG;
            wr_ptr_reg   <= '0;
            pre_cnt_reg  <= '0;
            post_cnt_reg <= '0;
            armed_reg    <= 1'b1;
          end
        end

        PRETRIG: begin
          // trig is deliberately not looked at: the window must fill first.
          if (pre_cnt_reg == {1'b0, trig_pos}) begin
            state_reg <= WAIT_TRIG;
          end else if (keep) begin
            pre_cnt_reg <= pre_cnt_reg + 1'b1;
          end
        end

        WAIT_TRIG: begin
          if (trig) begin
            // A byte kept in this same cycle is written at wr_ptr_reg, so it
            // becomes the first post-trigger byte.
            trig_addr_reg <= wr_ptr_reg;
            post_cnt_reg  <= post_cnt_next;
            armed_reg     <= 1'b0;
            triggered_reg <= 1'b1;
            if (post_cnt_next == post_limit) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= POST;
            end
          end
        end

        POST: begin
          if (keep) begin
            post_cnt_reg <= post_cnt_next;
            if (post_cnt_next == post_limit) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end

        DONE: begin
          // A coincident arm is dropped: IDLE only accepts it next cycle.
          if (clr_done) begin
            state_reg     <= IDLE;
            triggered_reg <= 1'b0;
            done_reg      <= 1'b0;
          end
        end

        default: begin
          state_reg     <= IDLE;
          armed_reg     <= 1'b0;
          triggered_reg <= 1'b0;
          done_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign we           = we_reg;
  assign waddr        = waddr_reg;
  assign wdata        = wdata_reg;
  assign armed        = armed_reg;
  assign triggered    = triggered_reg;
  assign capture_done = done_reg;
  assign trig_addr    = trig_addr_reg;

endmodule

// File: tb/tb_smpl_capture.sv
// tb_smpl_capture: randomized capture runs against a behavioural reference
// model. The model pushes each expected RAM write into a queue; a monitor pops
// and compares whenever the DUT raises we, and checks the status outputs.
module tb_smpl_capture;

  localparam int ADDR_W = 9;
  localparam int DEC_W  = 4;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        smpl;
  logic              smpl_vld;
  logic [DEC_W-1:0]  decimator;
  logic [ADDR_W-1:0] trig_pos;
  logic              arm;
  logic              trig;
  logic              clr_done;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;
  logic              armed;
  logic              triggered;
  logic              capture_done;
  logic [ADDR_W-1:0] trig_addr;

  int checks = 0;
  int errors = 0;

  smpl_capture #(.ADDR_W(ADDR_W), .DEC_W(DEC_W)) dut (
    .clk(clk), .rst(rst), .smpl(smpl), .smpl_vld(smpl_vld),
    .decimator(decimator), .trig_pos(trig_pos), .arm(arm), .trig(trig),
    .clr_done(clr_done), .we(we), .waddr(waddr), .wdata(wdata),
    .armed(armed), .triggered(triggered), .capture_done(capture_done),
    .trig_addr(trig_addr)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 filling pre-trigger window, 2 waiting for trigger,
  // 3 filling post-trigger part, 4 done.
  int m_phase = 0;
  int m_wp = 0;        // next RAM address
  int m_vcount = 0;    // valid bytes seen since arm
  int m_pre = 0;       // kept pre-trigger bytes
  int m_post = 0;      // kept post-trigger bytes
  int m_taddr = 0;     // expected trig_addr
  int m_nwr = 0;       // writes since arm
  logic [16:0] exp_q[$];

  always @(posedge clk) begin : model
    int  ratio;
    int  limit;
    int  wp0;
    bit  keep;
    if (rst) begin
      m_phase = 0; m_wp = 0; m_vcount = 0; m_pre = 0; m_post = 0;
      m_taddr = 0; m_nwr = 0;
      exp_q.delete();
    end else begin
      ratio = 1 << decimator;
      keep  = smpl_vld && ((m_vcount % ratio) == ratio - 1);
      if (smpl_vld) m_vcount++;
      wp0 = m_wp;
      if (keep && m_phase >= 1 && m_phase <= 3) begin
        exp_q.push_back({9'(m_wp), smpl});
        m_wp = (m_wp + 1) % DEPTH;
        m_nwr++;
      end
      limit = DEPTH - int'(trig_pos);
      case (m_phase)
        0: if (arm) begin
             m_phase = 1; m_wp = 0; m_vcount = 0; m_pre = 0; m_post = 0; m_nwr = 0;
           end
        1: if (m_pre == int'(trig_pos)) m_phase = 2;
           else if (keep) m_pre++;
        2: if (trig) begin
             m_taddr = wp0;
             m_post  = keep ? 1 : 0;
             m_phase = (m_post == limit) ? 4 : 3;
           end
        3: if (keep) begin
             m_post++;
             if (m_post == limit) m_phase = 4;
           end
        4: if (clr_done) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  bit mon_en = 1'b0;
  bit prev_done = 1'b0;
  int last_waddr = 0;

  always @(negedge clk) begin : monitor
    logic [16:0] e;
    int exp_last;
    if (mon_en) begin
      if (we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got waddr=%0d wdata=%02h, expected no write", waddr, wdata);
        end else begin
          e = exp_q.pop_front();
          if ({waddr, wdata} !== e) begin
            errors++;
            $display("FAIL write_data: got waddr=%0d wdata=%02h, expected waddr=%0d wdata=%02h",
                     waddr, wdata, e[16:8], e[7:0]);
          end
        end
        last_waddr = int'(waddr);
      end else if (exp_q.size() != 0) begin
        checks++;
        errors++;
        e = exp_q.pop_front();
        $display("FAIL write_missing: got we=0, expected write waddr=%0d wdata=%02h", e[16:8], e[7:0]);
      end

      checks++;
      if ({armed, triggered, capture_done} !== {(m_phase == 1 || m_phase == 2),
                                                (m_phase == 3 || m_phase == 4),
                                                (m_phase == 4)}
          || int'(trig_addr) != m_taddr) begin
        errors++;
        $display("FAIL status: got armed=%0b triggered=%0b done=%0b trig_addr=%0d, expected phase=%0d trig_addr=%0d",
                 armed, triggered, capture_done, trig_addr, m_phase, m_taddr);
      end

      // Last post-trigger write must sit just below the oldest retained byte.
      if (capture_done && !prev_done) begin
        exp_last = (m_taddr - int'(trig_pos) - 1 + 2 * DEPTH) % DEPTH;
        checks++;
        if (last_waddr != exp_last) begin
          errors++;
          $display("FAIL last_waddr: got %0d, expected %0d", last_waddr, exp_last);
        end
      end
      prev_done = capture_done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_capture(input string name, input int dec, input int tpos,
                             input int trig_at, input int min_wr, input int vld_pct,
                             input bit noise, input bit rst_mid, input bit arm_clr);
    int cyc = 0;
    decimator = DEC_W'(dec);
    trig_pos  = ADDR_W'(tpos);
    smpl_vld  = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    while (m_phase != 4 && cyc < 40000) begin
      smpl     = 8'($urandom);
      smpl_vld = ($urandom_range(99) < vld_pct);
      trig     = (m_phase == 2 && m_wp == trig_at && m_nwr >= min_wr) ||
                 (noise && m_phase == 1 && $urandom_range(3) == 0);
      arm      = ($urandom_range(15) == 0);  // never honoured mid-capture
      if (rst_mid && m_phase == 3 && m_post > 20) begin
        trig = 1'b0; arm = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (we !== 1'b0 || waddr !== '0 || trig_addr !== '0 || capture_done !== 1'b0 || armed !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_post: got we=%0b waddr=%0d trig_addr=%0d done=%0b armed=%0b, expected all 0",
                   we, waddr, trig_addr, capture_done, armed);
        end
        $display("capture %s: dec=%0d trig_pos=%0d aborted by reset after %0d cycles", name, dec, tpos, cyc);
        smpl_vld = 1'b0;
        return;
      end
      tick();
      cyc++;
    end
    trig = 1'b0; arm = 1'b0;
    checks++;
    if (cyc >= 40000) begin
      errors++;
      $display("FAIL %s_timeout: got no capture_done within 40000 cycles, expected done", name);
    end else if (capture_done !== 1'b1 || int'(trig_addr) != trig_at) begin
      errors++;
      $display("FAIL %s_result: got done=%0b trig_addr=%0d, expected done=1 trig_addr=%0d",
               name, capture_done, trig_addr, trig_at);
    end
    // Keep bytes flowing in DONE: the monitor flags any stray write.
    repeat (8) begin
      smpl = 8'($urandom); smpl_vld = 1'b1; tick();
    end
    smpl_vld = 1'b0;
    clr_done = 1'b1;
    arm      = arm_clr;
    tick();
    clr_done = 1'b0;
    arm      = 1'b0;
    checks++;
    if (armed !== 1'b0 || capture_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_clr: got armed=%0b done=%0b, expected 0 0", name, armed, capture_done);
    end
    $display("capture %s: dec=%0d trig_pos=%0d trig_addr=%0d cycles=%0d", name, dec, tpos, trig_addr, cyc);
  endtask

  initial begin
    rst = 1'b1; smpl = '0; smpl_vld = 1'b0; decimator = '0; trig_pos = '0;
    arm = 1'b0; trig = 1'b0; clr_done = 1'b0;
    repeat (3) tick();
    checks++;
    if (we !== 1'b0 || waddr !== '0 || wdata !== '0 || armed !== 1'b0 || triggered !== 1'b0 ||
        capture_done !== 1'b0 || trig_addr !== '0) begin
      errors++;
      $display("FAIL reset_state: got we=%0b waddr=%0d wdata=%02h armed=%0b trig=%0b done=%0b taddr=%0d, expected all 0",
               we, waddr, wdata, armed, triggered, capture_done, trig_addr);
    end
    rst = 1'b0;
    mon_en = 1'b1;

    run_capture("trig_third",  0,   0,   2,    0, 100, 1'b0, 1'b0, 1'b0);
    run_capture("decimate4",   2,  50, 200,    0, 100, 1'b0, 1'b0, 1'b0);
    run_capture("pretrig100",  0, 100, 300,    0, 100, 1'b1, 1'b0, 1'b0);
    run_capture("wrap500",     0, 500,  40, 1100,  80, 1'b1, 1'b0, 1'b0);
    run_capture("rst_post",    1,  64, 128,    0,  70, 1'b0, 1'b1, 1'b0);
    run_capture("arm_clr",     1,  10,  77,    0,  60, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      run_capture("random", $urandom_range(1), $urandom_range(511), $urandom_range(511),
                  0, $urandom_range(100, 50), 1'b1, 1'b0, 1'($urandom_range(1)));
    end
    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
